// File: rtl/fb_pixel_port.sv
// Framebuffer pixel port: reads go straight to a single-port SRAM, write-backs are
// paired with the address read CLKWAIT cycles earlier and queued until SRAM is free.
module fb_pixel_port #(
  parameter int CLKWAIT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] pixel_number,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  write_r,
  input  logic [7:0]  write_g,
  input  logic [7:0]  write_b,
  input  logic        frame_ready,
  output logic [7:0]  read_r,
  output logic [7:0]  read_g,
  output logic [7:0]  read_b,
  output logic        busy,
  output logic        frame_done,
  output logic        sram_en,
  output logic        sram_we,
  output logic [18:0] sram_addr,
  output logic [23:0] sram_wdata,
  input  logic [23:0] sram_rdata
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CLKWAIT-1:0] vld_dl;
  logic [18:0]        addr_dl [CLKWAIT];
  logic [18:0]        fifo_addr [FIFO_DEPTH];
  logic [23:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               overflow, busy_q;
  logic [23:0]        rgb, wdata_in, fwd_data, fwd_data_p1, ret_data, pre_out;
  logic               fwd_hit, fwd_hit_p1;
  logic               push_req, push, pop, full, empty;

  assign wdata_in  = {write_r, write_g, write_b};
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push_req  = write && vld_dl[CLKWAIT-1];
  assign pop       = !read && !empty;
  assign push      = push_req && (!full || pop);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Youngest match wins: scan oldest to youngest, then the write being pushed now.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count && fifo_addr[head + PTR_W'(i)] == pixel_number) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[head + PTR_W'(i)];
      end
    end
    if (push && addr_dl[CLKWAIT-1] == pixel_number) begin
      fwd_hit  = 1'b1;
      fwd_data = wdata_in;
    end
  end

  // p1: SRAM data (or forwarded data) arrives one cycle after the read
  assign ret_data = fwd_hit_p1 ? fwd_data_p1 : sram_rdata;

  generate
    if (CLKWAIT == 2) begin : g_direct
      assign pre_out = ret_data;
    end else begin : g_pipe
      logic [23:0] data_pipe [CLKWAIT-2];
      always_ff @(posedge clk) begin
        data_pipe[0] <= ret_data;
        for (int k = 1; k < CLKWAIT - 2; k++) data_pipe[k] <= data_pipe[k-1];
      end
      assign pre_out = data_pipe[CLKWAIT-3];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_dl   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy_q   <= 1'b0;
      rgb      <= '0;
    end else begin
      vld_dl <= {vld_dl[CLKWAIT-2:0], read};
      if (push) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      count <= count_nxt;
      if (push_req && !push) overflow <= 1'b1;
      busy_q <= (count_nxt >= CNT_W'(FIFO_DEPTH - 2)) || (state_nxt == DRAIN);
      if (vld_dl[CLKWAIT-2]) rgb <= pre_out;
    end
  end

  always_ff @(posedge clk) begin
    addr_dl[0] <= pixel_number;
    for (int k = 1; k < CLKWAIT; k++) addr_dl[k] <= addr_dl[k-1];
    if (push) begin
      fifo_addr[tail] <= addr_dl[CLKWAIT-1];
      fifo_data[tail] <= wdata_in;
    end
    fwd_hit_p1  <= fwd_hit;
    fwd_data_p1 <= fwd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_ready) state_nxt = DRAIN;
      DRAIN:   if (empty && vld_dl == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, so nothing reaches SRAM then.
  always_comb begin
    {read_r, read_g, read_b} = '0;
    busy       = 1'b0;
    frame_done = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!reset) begin
      {read_r, read_g, read_b} = rgb;
      busy       = busy_q;
      frame_done = (state == DONE);
      sram_en    = read || pop;
      sram_we    = pop;
      if (read) begin
        sram_addr = pixel_number;
      end else if (pop) begin
        sram_addr  = fifo_addr[head];
        sram_wdata = fifo_data[head];
      end
    end
  end

  ovf_clear: assert property (@(posedge clk) reset |=> !overflow);

endmodule

// File: tb/tb_fb_pixel_port.sv
// Directed bench for fb_pixel_port (CLKWAIT=2, FIFO_DEPTH=4) with a behavioural SRAM.
module tb_fb_pixel_port;
  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] pixel_number;
  logic        read, write, frame_ready;
  logic [7:0]  write_r, write_g, write_b, read_r, read_g, read_b;
  logic        busy, frame_done, sram_en, sram_we;
  logic [18:0] sram_addr;
  logic [23:0] sram_wdata, sram_rdata;

  logic [23:0] mem [0:1023];
  bit          mem_wr [0:1023];
  int          nvec = 0, nmis = 0;
  int          wr_cnt = 0, fd_cnt = 0;
  logic [23:0] s_rgb, s_wdata;
  logic [18:0] s_addr;
  logic        s_busy, s_fd, s_en, s_we;

  always #5 clk = ~clk;

  fb_pixel_port #(.CLKWAIT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pixel_number(pixel_number), .read(read), .write(write),
    .write_r(write_r), .write_g(write_g), .write_b(write_b), .frame_ready(frame_ready),
    .read_r(read_r), .read_g(read_g), .read_b(read_b), .busy(busy), .frame_done(frame_done),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  function automatic logic [23:0] init_val(input int a);
    return (a == 5) ? 24'h102030 : (24'hC00000 | 24'(a));
  endfunction

  function automatic logic [23:0] peek(input int a);
    return mem_wr[a] ? mem[a] : init_val(a);
  endfunction

  // SRAM: one-cycle read latency, write on en&we
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr[9:0]]    <= sram_wdata;
        mem_wr[sram_addr[9:0]] <= 1'b1;
      end else begin
        sram_rdata <= peek(int'(sram_addr[9:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (sram_en && sram_we) wr_cnt++;
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic [18:0] a, input logic wr,
                     input logic [23:0] d, input logic fr);
    read = rd; pixel_number = a; write = wr; frame_ready = fr;
    {write_r, write_g, write_b} = d;
    @(negedge clk);
    s_rgb = {read_r, read_g, read_b}; s_busy = busy; s_fd = frame_done;
    s_en = sram_en; s_we = sram_we; s_addr = sram_addr; s_wdata = sram_wdata;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 19'd0, 1'b0, 24'd0, 1'b0);
  endtask

  logic [18:0] h_addr [0:63];
  bit          h_vld  [0:63];
  int          nxt, first_busy, w0, f0, fd_t;
  logic        rd_b, wr_b, fr_b;
  logic [18:0] ad;
  logic [23:0] dt;

  initial begin
    reset = 1'b1;
    cyc(1'b0, 19'd0, 1'b0, 24'd0, 1'b0);
    chk("rst_rgb", 32'(s_rgb), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_sram_en", 32'(s_en), 0);
    cyc(1'b1, 19'd3, 1'b1, 24'h123456, 1'b1);
    chk("rst_sram_we", 32'(s_we), 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_fd", 32'(s_fd), 0);
    reset = 1'b0;
    chk("rst_state", 32'(dut.state), 0);
    chk("rst_count", 32'(dut.count), 0);

    // single read / write-back
    cyc(1'b1, 19'd5, 1'b0, 24'd0, 1'b0);
    chk("rd_en", 32'({s_en, s_we}), 32'b10);
    idle(1);
    cyc(1'b0, 19'd0, 1'b1, 24'hAABBCC, 1'b0);
    chk("rd_data", 32'(s_rgb), 32'h102030);
    idle(1);
    chk("wb_we", 32'(s_we), 1);
    chk("wb_addr", 32'(s_addr), 5);
    chk("rd_hold", 32'(s_rgb), 32'h102030);
    chk("wb_mem5", 32'(peek(5)), 32'hAABBCC);
    // write with no matching read slot must vanish
    w0 = wr_cnt;
    cyc(1'b0, 19'd0, 1'b1, 24'hEEEEEE, 1'b0);
    idle(3);
    chk("orphan_wr", 32'(wr_cnt - w0), 0);

    // forwarding from the same-cycle push and from the queue
    cyc(1'b1, 19'd7, 1'b0, 24'd0, 1'b0);
    cyc(1'b1, 19'd8, 1'b0, 24'd0, 1'b0);
    cyc(1'b1, 19'd7, 1'b1, 24'h112233, 1'b0);
    chk("fwd_stale", 32'(s_rgb), 32'hC00007);
    cyc(1'b1, 19'd7, 1'b0, 24'd0, 1'b0);
    idle(1);
    chk("fwd_push", 32'(s_rgb), 32'h112233);
    idle(1);
    chk("fwd_fifo", 32'(s_rgb), 32'h112233);
    idle(1);
    chk("fwd_mem7", 32'(peek(7)), 32'h112233);
    chk("fwd_mem8", 32'(peek(8)), 32'hC00008);

    // two queued writes to one address: youngest is returned and lands last
    cyc(1'b1, 19'd9, 1'b0, 24'd0, 1'b0);
    cyc(1'b1, 19'd9, 1'b0, 24'd0, 1'b0);
    cyc(1'b1, 19'd1, 1'b1, 24'h0A0A0A, 1'b0);
    cyc(1'b1, 19'd2, 1'b1, 24'h0B0B0B, 1'b0);
    cyc(1'b1, 19'd9, 1'b0, 24'd0, 1'b0);
    idle(1);
    chk("young_prev", 32'(s_rgb), 32'hC00002);
    idle(1);
    chk("young_fwd", 32'(s_rgb), 32'h0B0B0B);
    idle(2);
    chk("young_mem9", 32'(peek(9)), 32'h0B0B0B);

    // streaming reads that honour busy
    nxt = 0; first_busy = -1;
    for (int t = 0; t < 40; t++) begin
      rd_b = !busy && nxt < 10;
      wr_b = (t >= 2) ? h_vld[t-2] : 1'b0;
      ad   = (t >= 2) ? h_addr[t-2] : 19'd0;
      cyc(rd_b, 19'(100 + nxt), wr_b, 24'h5A0000 | 24'(ad), 1'b0);
      h_vld[t] = rd_b; h_addr[t] = 19'(100 + nxt);
      if (rd_b) nxt++;
      if (s_busy && first_busy < 0) first_busy = t;
    end
    chk("strm_busy_t", 32'(first_busy), 4);
    chk("strm_reads", 32'(nxt), 10);
    for (int i = 0; i < 10; i++) chk("strm_mem", 32'(peek(100 + i)), 32'(24'h5A0000 | 24'(100 + i)));
    chk("strm_ovf", 32'(dut.overflow), 0);

    // frame end with three queued entries
    w0 = wr_cnt; f0 = fd_cnt; fd_t = -1;
    for (int t = 0; t < 20; t++) begin
      rd_b = (t < 5);
      ad   = (t < 3) ? 19'(20 + t) : 19'd0;
      wr_b = (t >= 2 && t < 5);
      dt   = 24'h2F0000 | 24'(20 + t - 2);
      fr_b = (t >= 5 && t <= 8);
      cyc(rd_b, ad, wr_b, dt, fr_b);
      if (t == 4) chk("frm_count", 32'(dut.count), 3);
      if (t == 6) chk("frm_busy", 32'(s_busy), 1);
      if (s_fd && fd_t < 0) fd_t = t;
    end
    chk("frm_writes", 32'(wr_cnt - w0), 3);
    chk("frm_fd_cnt", 32'(fd_cnt - f0), 1);
    chk("frm_fd_t", 32'(fd_t), 9);
    for (int i = 0; i < 3; i++) chk("frm_mem", 32'(peek(20 + i)), 32'(24'h2F0000 | 24'(20 + i)));

    // overflow: five pushes, no drain slot
    w0 = wr_cnt;
    for (int t = 0; t < 15; t++) begin
      rd_b = (t <= 6);
      ad   = (t < 5) ? 19'(40 + t) : 19'd0;
      wr_b = (t >= 2 && t <= 6);
      dt   = 24'h3C0000 | 24'(40 + t - 2);
      cyc(rd_b, ad, wr_b, dt, 1'b0);
      if (t == 5) chk("ovf_pre", 32'(dut.overflow), 0);
      if (t == 6) begin
        chk("ovf_set", 32'(dut.overflow), 1);
        chk("ovf_count", 32'(dut.count), 4);
        chk("ovf_nodrain", 32'(wr_cnt - w0), 0);
      end
    end
    chk("ovf_writes", 32'(wr_cnt - w0), 4);
    for (int i = 0; i < 4; i++) chk("ovf_mem", 32'(peek(40 + i)), 32'(24'h3C0000 | 24'(40 + i)));
    chk("ovf_drop", 32'(peek(44)), 32'hC0002C);
    chk("ovf_sticky", 32'(dut.overflow), 1);

    // reset in the middle of a frame drain
    f0 = fd_cnt;
    for (int t = 0; t < 16; t++) begin
      rd_b = (t < 5);
      ad   = (t < 3) ? 19'(60 + t) : 19'd0;
      wr_b = (t >= 2 && t < 5);
      dt   = 24'h660000 | 24'(60 + t - 2);
      reset = (t == 6);
      if (t == 6) w0 = wr_cnt;
      cyc(rd_b, ad, wr_b, dt, t == 5);
      if (t == 5) chk("mrst_drain", 32'(dut.state), 1);
      if (t == 6) begin
        chk("mrst_out", 32'({s_rgb, s_busy, s_fd, s_en, s_we}), 0);
        chk("mrst_state", 32'(dut.state), 0);
        chk("mrst_count", 32'(dut.count), 0);
        chk("mrst_ovf", 32'(dut.overflow), 0);
      end
    end
    reset = 1'b0;
    chk("mrst_writes", 32'(wr_cnt - w0), 0);
    chk("mrst_fd", 32'(fd_cnt - f0), 0);
    chk("mrst_mem60", 32'(peek(60)), 32'h66003C);
    chk("mrst_mem61", 32'(peek(61)), 32'hC0003D);
    chk("mrst_mem62", 32'(peek(62)), 32'hC0003E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/fb_pixel_port.md
FB_PIXEL_PORT -- requirements
Module: fb_pixel_port

Interface
REQ-001 SHALL have parameter CLKWAIT, default 2, meaning cycles from read request to write-back; legal values 2..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of write-buffer entries; power of two, at least 4.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port pixel_number, input, 19 bits, the pixel address sampled when read=1.
REQ-006 SHALL have port read, input, 1 bit, a read request for pixel_number.
REQ-007 SHALL have port write, input, 1 bit, a write-back strobe for the pixel read CLKWAIT cycles earlier.
REQ-008 SHALL have ports write_r, write_g, write_b, inputs, 8 bits each, the write-back colour.
REQ-009 SHALL have port frame_ready, input, 1 bit, a frame-end request.
REQ-010 SHALL have ports read_r, read_g, read_b, outputs, 8 bits each, the returned colour.
REQ-011 SHALL have port busy, output, 1 bit, telling upstream to hold off new reads.
REQ-012 SHALL have port frame_done, output, 1 bit, a one-cycle pulse when a frame is committed.
REQ-013 SHALL have SRAM ports sram_en (out, 1), sram_we (out, 1), sram_addr (out, 19), sram_wdata (out, 24, {r,g,b}) and sram_rdata (in, 24).

Function
REQ-014 SHALL model the SRAM as single-port with a read latency of 1: sram_rdata is valid the cycle after sram_en=1, sram_we=0.
REQ-015 SHALL issue a read to SRAM in the same cycle read=1; reads always win SRAM arbitration.
REQ-016 SHALL present read data on read_r/g/b exactly CLKWAIT cycles after the read cycle, registered, and hold it until the next read returns.
REQ-017 SHALL carry each read address through a CLKWAIT-deep delay line; a write in cycle N pairs with the address read in cycle N-CLKWAIT.
REQ-018 SHALL ignore and not enqueue a write whose delay-line slot holds no valid read.
REQ-019 SHALL push each paired write into a FIFO_DEPTH FIFO holding address and 24-bit data.
REQ-020 SHALL drain the FIFO head to SRAM (sram_en=1, sram_we=1) on any cycle without a read; one entry per cycle, in order.
REQ-021 SHALL allow a push and a drain in the same cycle, leaving the count unchanged.
REQ-022 SHALL drive busy=1 while the FIFO count is FIFO_DEPTH-2 or more, and SHALL register busy.
REQ-023 SHALL drop a write to a full FIFO, hold the FIFO contents unchanged, and set a sticky internal overflow flag that is cleared only by reset.
REQ-024 SHALL forward on a read address match: if the address equals a FIFO entry or the write being pushed that cycle, the returned data is the youngest match, not sram_rdata.
REQ-025 SHALL implement a frame FSM with states IDLE, DRAIN and DONE.
REQ-026 SHALL move the frame FSM from IDLE to DRAIN on frame_ready=1.
REQ-027 SHALL hold busy=1 in DRAIN and move to DONE when the FIFO is empty and the delay line holds no valid slot.
REQ-028 SHALL pulse frame_done=1 for one cycle in DONE, then return to IDLE.
REQ-029 SHALL ignore frame_ready asserted while in DRAIN or DONE.
REQ-030 SHALL still complete pending write-backs in DRAIN; a read arriving in DRAIN is still served.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, clear the FIFO, delay line, overflow flag and frame FSM, leaving the FSM in IDLE.
REQ-032 SHALL drive all outputs to 0 during reset: read_r/g/b, busy, frame_done, sram_en, sram_we, sram_addr and sram_wdata.
REQ-033 SHALL discard in-flight reads and writes when reset is asserted mid-operation; no SRAM write occurs in a reset cycle.

Verification
REQ-034 SHALL pass single read/write: SRAM[5]=0x102030, read at cycle 0 addr 5 -> read_r/g/b=0x10/0x20/0x30 at cycle 2; write 0xAABBCC at cycle 2 -> SRAM[5]=0xAABBCC by cycle 3.
REQ-035 SHALL pass streaming: reads on every cycle for addresses 0..9 -> busy rises once count reaches 2, no write is lost when upstream honours busy, and SRAM ends holding all 10 values.
REQ-036 SHALL pass forwarding: write 0x112233 to addr 7 queued while reads are back-to-back, then read addr 7 -> returns 0x112233, not the stale SRAM value.
REQ-037 SHALL pass frame end: frame_ready with 3 entries queued and no reads -> 3 SRAM writes, then frame_done high for exactly one cycle.
REQ-038 SHALL pass overflow: 5 writes with no drain opportunity -> the 5th write is dropped, the overflow flag is set, and the FIFO contents stay intact.
REQ-039 SHALL pass reset mid-drain: reset during DRAIN -> state IDLE, FIFO empty, frame_done never pulses, and no further SRAM write occurs.
